// File: rtl/feature_map_streamer.sv
// Streams a snapshot of the flattened pooled feature map as valid/ready beats,
// each tagged with its (filter,row,col) coordinates.
module feature_map_streamer #(
    parameter  int POOL_SIZE   = 2,
    parameter  int NUM_FILTERS = 3,
    parameter  int DATA_W      = 16,
    localparam int N_ELEMS     = POOL_SIZE * POOL_SIZE * NUM_FILTERS,
    localparam int F_W         = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
    localparam int RC_W        = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1,
    localparam int IDX_W       = (N_ELEMS > 1) ? $clog2(N_ELEMS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_ELEMS-1:0][DATA_W-1:0]   fm_in,
    input  logic                             fm_done,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic signed [DATA_W-1:0]         m_data,
    output logic [F_W-1:0]                   m_filter,
    output logic [RC_W-1:0]                  m_row,
    output logic [RC_W-1:0]                  m_col,
    output logic                             m_last,
    output logic                             busy,
    input  logic                             clr_drop,
    output logic                             frame_drop,
    output logic [7:0]                       frames_sent
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                           state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [F_W-1:0]                   f_q, f_d;
    logic [RC_W-1:0]                  r_q, r_d, c_q, c_d;
    logic                             done_q;
    logic                             drop_q, drop_d;
    logic [7:0]                       sent_q, sent_d;
    logic [N_ELEMS-1:0][DATA_W-1:0]   buffer;

    logic rise, xfer, last_xfer, capture;

    assign rise      = fm_done & ~done_q;
    assign xfer      = m_valid & m_ready;
    assign last_xfer = xfer & m_last;
    // A rise on the final handshake starts the next frame with no idle bubble.
    assign capture   = rise & ((state_q == IDLE) | last_xfer);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        idx_d   = idx_q;
        f_d     = f_q;
        r_d     = r_q;
        c_d     = c_q;
        drop_d  = drop_q;
        sent_d  = sent_q;

        case (state_q)
            IDLE:   if (rise) state_d = STREAM;
            STREAM: if (last_xfer && !rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (capture) begin
            idx_d = '0;
            f_d   = '0;
            r_d   = '0;
            c_d   = '0;
        end else if (xfer) begin
            idx_d = idx_q + 1'b1;
            if (c_q == RC_W'(POOL_SIZE - 1)) begin
                c_d = '0;
                if (r_q == RC_W'(POOL_SIZE - 1)) begin
                    r_d = '0;
                    f_d = f_q + 1'b1;
                end else begin
                    r_d = r_q + 1'b1;
                end
            end else begin
                c_d = c_q + 1'b1;
            end
        end

        if (last_xfer) sent_d = sent_q + 8'd1;

        // Set dominates clear when a discarded frame coincides with clr_drop.
        if (state_q == STREAM && rise && !last_xfer) drop_d = 1'b1;
        else if (clr_drop)                           drop_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            f_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            f_q     <= f_d;
            r_q     <= r_d;
            c_q     <= c_d;
            done_q  <= fm_done;
            drop_q  <= drop_d;
            sent_q  <= sent_d;
        end
    end

    // NOTE: the snapshot buffer has no reset; it is only read after a capture has filled it.
    always_ff @(posedge clk) begin
        if (capture) buffer <= fm_in;
    end

    assign m_valid     = (state_q == STREAM);
    assign busy        = (state_q == STREAM);
    assign m_data      = buffer[idx_q];
    assign m_filter    = f_q;
    assign m_row       = r_q;
    assign m_col       = c_q;
    assign m_last      = (idx_q == IDX_W'(N_ELEMS - 1));
    assign frame_drop  = drop_q;
    assign frames_sent = sent_q;

endmodule
